// File: rtl/brailliance_cell_sequencer.sv
// Braille cell sequencer: queues 6-dot cell patterns and plays them out on a
// pin driver with a programmable dwell time and an inter-cell blank gap.
module brailliance_cell_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMER_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [5:0]                    in_dots,
    input  logic [TIMER_W-1:0]            dwell,
    input  logic [TIMER_W-1:0]            gap,
    input  logic                          pause,
    input  logic                          flush,
    output logic [5:0]                    dots_out,
    output logic                          dots_strobe,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t               state, state_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic [TIMER_W-1:0]   gap_q, gap_nxt;
    logic [5:0]           dots_nxt;
    logic                 strobe_nxt;
    logic                 push, pop;

    logic [5:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    // A same-cycle pop never frees space early: readiness looks only at the
    // registered occupancy.
    assign in_ready = !rst && !flush && (fifo_count < CW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        gap_nxt    = gap_q;
        dots_nxt   = dots_out;
        strobe_nxt = 1'b0;
        pop        = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            dots_nxt  = '0;
        end else if (!pause) begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        dots_nxt   = mem[rd_ptr];
                        timer_nxt  = (dwell == '0) ? TIMER_W'(1) : dwell;
                        gap_nxt    = gap;
                        strobe_nxt = 1'b1;
                        state_nxt  = SHOW;
                    end
                end
                SHOW: begin
                    if (timer <= TIMER_W'(1)) begin
                        dots_nxt = '0;
                        if (gap_q == '0) begin
                            state_nxt = IDLE;
                            timer_nxt = '0;
                        end else begin
                            state_nxt = GAP;
                            timer_nxt = gap_q;
                        end
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                GAP: begin
                    if (timer <= TIMER_W'(1)) begin
                        state_nxt = IDLE;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer - TIMER_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    dots_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            gap_q       <= '0;
            dots_out    <= '0;
            dots_strobe <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            gap_q       <= gap_nxt;
            dots_out    <= dots_nxt;
            dots_strobe <= strobe_nxt;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_dots;
    end

endmodule

// File: tb/tb_brailliance_cell_sequencer.sv
// Scoreboarded bench for brailliance_cell_sequencer: accepted cells queue their
// expected pattern and display length; a monitor pops them as cells appear.
module tb_brailliance_cell_sequencer;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMER_W    = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [5:0]            in_dots = '0;
    logic [TIMER_W-1:0]    dwell = '0;
    logic [TIMER_W-1:0]    gap = '0;
    logic                  pause = 1'b0;
    logic                  flush = 1'b0;
    logic [5:0]            dots_out;
    logic                  dots_strobe;
    logic                  busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    brailliance_cell_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMER_W(TIMER_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_dots(in_dots), .dwell(dwell), .gap(gap), .pause(pause), .flush(flush),
        .dots_out(dots_out), .dots_strobe(dots_strobe), .busy(busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q[$];
    int         len_q[$];
    int         gap_exp   = -1;
    bit         seen_cell = 1'b0;
    int         on_run    = 0;
    int         zrun      = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: cell order, display length and blank length between cells.
    initial begin
        forever begin
            @(negedge clk);
            if (dots_strobe) begin
                if (exp_q.size() == 0) chk("sb_extra", 1, 0);
                else                   chk("cell", 32'(dots_out), 32'(exp_q.pop_front()));
                if (gap_exp >= 0 && seen_cell) chk("gap", zrun, gap_exp);
            end
            if (dots_out != '0) begin
                on_run++;
                zrun = 0;
                seen_cell = 1'b1;
            end else begin
                if (on_run > 0 && len_q.size() > 0) chk("dwell", on_run, len_q.pop_front());
                on_run = 0;
                zrun++;
            end
        end
    end

    task automatic push_cell(input logic [5:0] d, input int len);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_dots  = d;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            exp_q.push_back(d);
            len_q.push_back(len);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || dots_out != '0) && t < 500);
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        len_q.delete();
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_dots", 32'(dots_out), 0);
        chk("rst_strobe", 32'(dots_strobe), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 1);

        // Single cell with exact timing; dwell changed mid-cell is ignored
        dwell = 3; gap = 2;
        push_cell(6'b101011, 3);
        @(negedge clk);
        chk("single_k_dots", 32'(dots_out), 0);
        chk("single_k_count", 32'(fifo_count), 1);
        @(negedge clk);
        chk("single_k1_dots", 32'(dots_out), 32'(6'b101011));
        chk("single_k1_strobe", 32'(dots_strobe), 1);
        dwell = 9;
        @(negedge clk);
        chk("single_k2_strobe", 32'(dots_strobe), 0);
        @(negedge clk);
        chk("single_k3_dots", 32'(dots_out), 32'(6'b101011));
        @(negedge clk);
        chk("single_k4_dots", 32'(dots_out), 0);
        @(negedge clk);
        chk("single_k5_busy", 32'(busy), 1);
        @(negedge clk);
        chk("single_k6_busy", 32'(busy), 0);

        // Back-to-back cells, gap 0 gives one blank cycle
        dwell = 2; gap = 0;
        seen_cell = 1'b0; gap_exp = 1;
        push_cell(6'h01, 2);
        chk("b2b_count_a", 32'(fifo_count), 1);
        push_cell(6'h02, 2);
        chk("b2b_count_b", 32'(fifo_count), 1);
        push_cell(6'h04, 2);
        chk("b2b_count_c", 32'(fifo_count), 2);
        wait_idle();

        // Full queue while paused; held 5th push, order after unpause
        dwell = 1; gap = 0;
        seen_cell = 1'b0; gap_exp = 1;
        pause = 1'b1;
        push_cell(6'h11, 1);
        push_cell(6'h12, 1);
        push_cell(6'h13, 1);
        push_cell(6'h14, 1);
        chk("full_count", 32'(fifo_count), 4);
        chk("full_ready", 32'(in_ready), 0);
        chk("full_dots", 32'(dots_out), 0);
        fork
            push_cell(6'h15, 1);
            begin
                repeat (3) @(negedge clk);
                chk("full_held", 32'(fifo_count), 4);
                pause = 1'b0;
            end
        join
        wait_idle();

        // Pause for 3 cycles after the 2nd display cycle: 7 visible cycles
        dwell = 4; gap = 1; gap_exp = -1;
        push_cell(6'b110011, 7);
        repeat (3) @(negedge clk);
        pause = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("pause_hold", 32'(dots_out), 32'(6'b110011));
        end
        chk("pause_strobe", 32'(dots_strobe), 0);
        pause = 1'b0;
        wait_idle();

        // Flush with one showing and three queued; concurrent push dropped
        dwell = 20; gap = 0;
        push_cell(6'h21, 20);
        push_cell(6'h22, 20);
        push_cell(6'h23, 20);
        push_cell(6'h24, 20);
        repeat (2) @(negedge clk);
        chk("flush_pre_count", 32'(fifo_count), 3);
        chk("flush_pre_dots", 32'(dots_out), 32'(6'h21));
        clear_sb();
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_dots = 6'h3F;
        #1;
        chk("flush_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_dots", 32'(dots_out), 0);
        chk("flush_count", 32'(fifo_count), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_strobe", 32'(dots_strobe), 0);
        repeat (3) @(negedge clk);
        chk("flush_drop", 32'(fifo_count), 0);
        chk("flush_dots_later", 32'(dots_out), 0);

        // Async reset mid-gap with two queued, then clean restart
        dwell = 2; gap = 10;
        push_cell(6'h31, 2);
        push_cell(6'h32, 2);
        push_cell(6'h33, 2);
        repeat (3) @(negedge clk);
        chk("gap_count", 32'(fifo_count), 2);
        chk("gap_busy", 32'(busy), 1);
        chk("gap_dots", 32'(dots_out), 0);
        clear_sb();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(fifo_count), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(in_ready), 0);
        chk("arst_dots", 32'(dots_out), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_rel_ready", 32'(in_ready), 1);
        gap = 0;
        push_cell(6'h3A, 2);
        wait_idle();

        chk("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/brailliance_cell_sequencer.md
BRAILLIANCE_CELL_SEQUENCER -- requirements
Module: brailliance_cell_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: braille-cell queue depth in entries, power of two, minimum 2.
REQ-002 Parameter TIMER_W, default 16: width of the dwell and gap timers in bits.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer offers a cell pattern.
REQ-006 in_ready  output  1  sequencer can accept a cell this cycle.
REQ-007 in_dots  input  6  cell dot pattern; bit i is dot i+1.
REQ-008 dwell  input  TIMER_W  cycles each cell is displayed; value 0 is treated as 1.
REQ-009 gap  input  TIMER_W  blank cycles after each cell, excluding the fixed idle cycle.
REQ-010 pause  input  1  freezes display sequencing.
REQ-011 flush  input  1  synchronous clear of the queue and display.
REQ-012 dots_out  output  6  registered pattern driving the actuator or pin driver.
REQ-013 dots_strobe  output  1  registered one-cycle pulse in the first cycle a new cell is on dots_out.
REQ-014 busy  output  1  cell queued or display not idle.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-016 The block SHALL accept a push on a rising edge when in_valid and in_ready are both high.
REQ-017 in_ready SHALL be combinational and high only when rst is low, flush is low and fifo_count < FIFO_DEPTH; a same-cycle pop SHALL NOT make a full queue ready.
REQ-018 The FSM SHALL have exactly three states: IDLE, SHOW and GAP.
REQ-019 In IDLE with fifo_count > 0 and pause low, the FSM SHALL pop the head, load dots_out, load the timer with max(dwell,1), assert dots_strobe for the next cycle, and enter SHOW.
REQ-020 A cell accepted into an empty queue on edge k while in IDLE SHALL appear on dots_out at edge k+1.
REQ-021 In SHOW the timer SHALL decrement each unpaused cycle; when the timer equals 1 the FSM SHALL set dots_out to 0 and enter GAP loaded with gap, or enter IDLE if gap is 0.
REQ-022 In GAP the timer SHALL decrement each unpaused cycle; when the timer equals 1 the FSM SHALL enter IDLE.
REQ-023 Each cell SHALL be on dots_out for exactly max(dwell,1) unpaused cycles.
REQ-024 Consecutive cells SHALL be separated by exactly gap+1 zero cycles on dots_out.
REQ-025 dwell and gap SHALL be sampled only at load time; changes mid-cell SHALL NOT affect the current cell.
REQ-026 While pause is high, state, timer and dots_out SHALL hold and no pop SHALL occur; pushes SHALL still be accepted.
REQ-027 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-028 The queue read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 flush SHALL take priority over push, pop and pause, and on that edge SHALL empty the queue, zero dots_out and the timer, clear dots_strobe and enter IDLE.
REQ-030 busy SHALL be high when the state is not IDLE or fifo_count is not 0.

Reset
REQ-031 While rst is high: dots_out = 0, dots_strobe = 0, busy = 0, fifo_count = 0, in_ready = 0, state = IDLE, timer = 0.
REQ-032 An assertion of rst mid-cell SHALL immediately blank dots_out and discard all queued cells.
REQ-033 On the first cycle after rst deasserts, in_ready SHALL be 1.

Verification
REQ-034 Single cell: dwell=3, gap=2, push 6'b101011 at edge k -> dots_out=101011 for edges k+1..k+3, dots_strobe high only after k+1, then 0; busy low from edge k+6.
REQ-035 Back-to-back cells: dwell=2, gap=0, push A,B,C -> each cell shown 2 cycles with 1 zero cycle between cells; fifo_count sequence is correct.
REQ-036 Full queue: 5 pushes while paused with FIFO_DEPTH=4 -> in_ready low after the 4th push; the 5th push is held by the producer; after unpause, order is preserved.
REQ-037 Pause mid-cell: dwell=4, pause for 3 cycles after the 2nd display cycle -> the cell is visible for 7 cycles total and the timer resumes at the correct count.
REQ-038 Flush with 3 queued and one showing -> next edge gives dots_out=0, fifo_count=0, busy=0; a push asserted with flush is dropped.
REQ-039 Async reset mid-GAP with 2 queued -> outputs go to reset values without a clock edge; the sequencer restarts cleanly after release.
